// File: rtl/mic_array_pkg.sv
// ---------------------------------------------------------------------------
// mic_array_pkg
// Shared definitions for the microphone-array processing chain: channel and
// sample geometry, the signed sample type, the beamformer FSM state type and
// a saturating arithmetic-shift helper used by this and later stages.
// ---------------------------------------------------------------------------
package mic_array_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;
    localparam int DATA_W = 32;

    // The accumulator holds the sum of NUM_CH full-scale samples without
    // overflow.
    localparam int ACC_W  = DATA_W + CH_W;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    typedef enum logic {
        ST_SYNC,
        ST_RUN
    } bf_state_t;

    typedef struct packed {
        sample_t data;
        logic    sat;
    } sat_result_t;

    // Arithmetic right shift followed by clamping to the DATA_W range.
    // Overflow is detected when the bits above the DATA_W sign bit are not
    // all copies of the accumulator sign.
    function automatic sat_result_t sat_shift(input acc_t value, input int shift);
        acc_t        shifted;
        sat_result_t r;
        shifted = value >>> shift;
        r.sat   = 1'b0;
        r.data  = shifted[DATA_W-1:0];
        if (shifted[ACC_W-1:DATA_W-1] != {(ACC_W-DATA_W+1){shifted[ACC_W-1]}}) begin
            r.sat  = 1'b1;
            r.data = shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                      : {1'b0, {(DATA_W-1){1'b1}}};
        end
        return r;
    endfunction

endpackage

// File: rtl/mic_hist_ram.sv
// ---------------------------------------------------------------------------
// mic_hist_ram
// Simple dual-port history RAM, one write port and one registered read port
// (one-cycle read latency). No reset so that it maps onto block RAM.
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write address {channel, frame pointer}
//   wr_data  : write data
//   rd_en    : read strobe
//   rd_addr  : read address {channel, delayed frame pointer}
//   rd_data  : read data, valid the cycle after rd_en
// ---------------------------------------------------------------------------
module mic_hist_ram
    import mic_array_pkg::*;
#(
    parameter int WIDTH  = DATA_W,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

    // Read-during-write to the same address returns the old word; the
    // beamformer never relies on that case (zero delay is bypassed).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/mic_delay_sum.sv
// ---------------------------------------------------------------------------
// mic_delay_sum
// Delay-and-sum beamformer. Accepts a channel-interleaved sample stream
// (channels 0..NUM_CH-1 per frame), delays each channel by a programmable
// number of frames through a circular history RAM, sums the taps and emits
// one shifted, saturated mono sample per complete frame.
//   clk_clk, reset_reset_n        : clock, asynchronous active-low reset
//   in_data/valid/channel/sop/eop/error : input stream, no backpressure
//   out_data/valid/sop/eop/error  : one pulse per frame, held between frames
//   slave_address/write/writedata : per-channel delay write port
// ---------------------------------------------------------------------------
module mic_delay_sum
    import mic_array_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DLY_W = $clog2(DEPTH),
    parameter int SHIFT = 3
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_channel,
    input  logic              in_startofpacket,
    input  logic              in_endofpacket,
    input  logic [1:0]        in_error,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_startofpacket,
    output logic              out_endofpacket,
    output logic [1:0]        out_error,
    input  logic [CH_W-1:0]   slave_address,
    input  logic              slave_write,
    input  logic [15:0]       slave_writedata
);

    localparam int ADDR_W = CH_W + DLY_W;

    bf_state_t         state, state_next;
    logic [CH_W-1:0]   exp_ch, exp_ch_next;
    logic              accept, frame_start, frame_end, lose_sync;
    logic              sync_lost;

    logic [DLY_W-1:0]  frame_ptr, fill_cnt, eff_dly, rd_ptr;
    logic [DLY_W-1:0]  dly_shadow [NUM_CH];
    logic [DLY_W-1:0]  dly_active [NUM_CH];
    logic              addr_ok;

    logic [DATA_W-1:0] rd_data;

    logic              s1_valid, s1_first, s1_last, s1_bypass, s1_gate;
    logic              s1_sop, s1_eop;
    logic [1:0]        s1_err;
    sample_t           s1_data;

    acc_t              acc, acc_sum;
    logic              sop_acc, eop_acc, sop_sum, eop_sum;
    logic [1:0]        err_acc, err_sum;
    sample_t           tap;
    sat_result_t       sat_res;

    logic              unused_bits;

    assign unused_bits = &{1'b0, slave_writedata[15:DLY_W], sync_lost};

    // Frame tracker: a sample is accepted when it carries the expected
    // channel, or when it is a channel-0 sample (which always starts a new
    // frame, even if it breaks the current one). Any other out-of-order
    // sample abandons the frame and waits for the next channel 0.
    always_comb begin
        state_next  = state;
        exp_ch_next = exp_ch;
        accept      = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        lose_sync   = 1'b0;
        if (in_valid) begin
            if (state == ST_RUN && in_channel == exp_ch) begin
                accept = 1'b1;
            end else if (in_channel == '0) begin
                accept    = 1'b1;
                lose_sync = (state == ST_RUN);
            end else if (state == ST_RUN) begin
                lose_sync  = 1'b1;
                state_next = ST_SYNC;
            end
            if (accept) begin
                state_next  = ST_RUN;
                frame_start = (in_channel == '0);
                frame_end   = (in_channel == CH_W'(NUM_CH - 1));
                exp_ch_next = frame_end ? '0 : in_channel + CH_W'(1);
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state     <= ST_SYNC;
            exp_ch    <= '0;
            sync_lost <= 1'b0;
        end else begin
            state  <= state_next;
            exp_ch <= exp_ch_next;
            if (lose_sync) begin
                sync_lost <= 1'b1;
            end
        end
    end

    // The channel-0 sample already uses the delay being promoted from the
    // shadow register, so a whole frame always sees one consistent set.
    always_comb begin
        eff_dly = frame_start ? dly_shadow[0] : dly_active[in_channel];
        rd_ptr  = frame_ptr - eff_dly;
        addr_ok = ({1'b0, slave_address} < (CH_W + 1)'(NUM_CH));
    end

    // Frame pointer, fill counter and delay registers. The fill counter
    // counts completed frames since reset so that taps reaching further back
    // than the written history are forced to zero.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            frame_ptr <= '0;
            fill_cnt  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                dly_shadow[i] <= '0;
                dly_active[i] <= '0;
            end
        end else begin
            if (frame_end) begin
                frame_ptr <= frame_ptr + DLY_W'(1);
                if (fill_cnt != DLY_W'(DEPTH - 1)) begin
                    fill_cnt <= fill_cnt + DLY_W'(1);
                end
            end
            if (frame_start) begin
                dly_active <= dly_shadow;
            end
            if (slave_write && addr_ok) begin
                dly_shadow[slave_address] <= slave_writedata[DLY_W-1:0];
            end
        end
    end

    mic_hist_ram #(
        .WIDTH  (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_hist_ram (
        .clk     (clk_clk),
        .wr_en   (accept),
        .wr_addr ({in_channel, frame_ptr}),
        .wr_data (in_data),
        .rd_en   (accept),
        .rd_addr ({in_channel, rd_ptr}),
        .rd_data (rd_data)
    );

    // Stage 1 lines the sample attributes up with the RAM read data.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_bypass <= 1'b0;
            s1_gate   <= 1'b0;
            s1_sop    <= 1'b0;
            s1_eop    <= 1'b0;
            s1_err    <= '0;
            s1_data   <= '0;
        end else begin
            s1_valid  <= accept;
            s1_first  <= frame_start;
            s1_last   <= frame_end;
            s1_bypass <= (eff_dly == '0);
            s1_gate   <= (eff_dly > fill_cnt);
            s1_sop    <= in_startofpacket;
            s1_eop    <= in_endofpacket;
            s1_err    <= in_error;
            s1_data   <= sample_t'(in_data);
        end
    end

    // Tap selection and running sum; channel 0 restarts the accumulation.
    always_comb begin
        tap     = s1_gate ? '0 : (s1_bypass ? s1_data : sample_t'(rd_data));
        acc_sum = (s1_first ? '0 : acc) + acc_t'(tap);
        sop_sum = (s1_first ? 1'b0 : sop_acc) | s1_sop;
        eop_sum = (s1_first ? 1'b0 : eop_acc) | s1_eop;
        err_sum = (s1_first ? 2'b00 : err_acc) | s1_err;
        sat_res = sat_shift(acc_sum, SHIFT);
    end

    // Stage 2 accumulates and, on the last channel, publishes the frame.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            acc               <= '0;
            sop_acc           <= 1'b0;
            eop_acc           <= 1'b0;
            err_acc           <= '0;
            out_data          <= '0;
            out_valid         <= 1'b0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_error         <= '0;
        end else begin
            out_valid <= 1'b0;
            if (s1_valid) begin
                acc     <= acc_sum;
                sop_acc <= sop_sum;
                eop_acc <= eop_sum;
                err_acc <= err_sum;
                if (s1_last) begin
                    out_valid         <= 1'b1;
                    out_data          <= sat_res.data;
                    out_startofpacket <= sop_sum;
                    out_endofpacket   <= eop_sum;
                    out_error         <= {err_sum[1] | sat_res.sat, err_sum[0]};
                end
            end
        end
    end

endmodule

// File: tb/tb_mic_delay_sum.sv
// ---------------------------------------------------------------------------
// tb_mic_delay_sum
// Drives two beamformer instances (SHIFT = 3 and SHIFT = 0) with identical
// stimulus. A frame-level reference model pushes the expected output of each
// instance into its own queue when the last channel of a frame is driven;
// monitors pop and compare whenever an instance pulses out_valid.
// ---------------------------------------------------------------------------
module tb_mic_delay_sum;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_channel = '0;
    logic        in_startofpacket = 1'b0;
    logic        in_endofpacket = 1'b0;
    logic [1:0]  in_error = '0;
    logic [2:0]  slave_address = '0;
    logic        slave_write = 1'b0;
    logic [15:0] slave_writedata = '0;

    logic [31:0] out_data_s3, out_data_s0;
    logic        out_valid_s3, out_valid_s0;
    logic        out_sop_s3, out_sop_s0;
    logic        out_eop_s3, out_eop_s0;
    logic [1:0]  out_error_s3, out_error_s0;

    always #5 clk_clk = ~clk_clk;

    mic_delay_sum #(.SHIFT(3)) dut_s3 (
        .clk_clk           (clk_clk),
        .reset_reset_n     (reset_reset_n),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_channel        (in_channel),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .in_error          (in_error),
        .out_data          (out_data_s3),
        .out_valid         (out_valid_s3),
        .out_startofpacket (out_sop_s3),
        .out_endofpacket   (out_eop_s3),
        .out_error         (out_error_s3),
        .slave_address     (slave_address),
        .slave_write       (slave_write),
        .slave_writedata   (slave_writedata)
    );

    mic_delay_sum #(.SHIFT(0)) dut_s0 (
        .clk_clk           (clk_clk),
        .reset_reset_n     (reset_reset_n),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_channel        (in_channel),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .in_error          (in_error),
        .out_data          (out_data_s0),
        .out_valid         (out_valid_s0),
        .out_startofpacket (out_sop_s0),
        .out_endofpacket   (out_eop_s0),
        .out_error         (out_error_s0),
        .slave_address     (slave_address),
        .slave_write       (slave_write),
        .slave_writedata   (slave_writedata)
    );

    int cyc = 0;
    always @(posedge clk_clk) cyc <= cyc + 1;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  err;
        int          due;
    } exp_t;

    exp_t q3[$];
    exp_t q0[$];

    // Reference model state, indexed by completed-frame number since reset.
    logic signed [31:0] modelHist [256][8];
    int                 nFrames;
    int                 modelShadow [8];
    int                 modelActive [8];

    logic signed [31:0] frameData [8];
    logic [1:0]         frameErr [8];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkPulse(input string who, input exp_t e, input logic [31:0] d,
                              input logic sop, input logic eop, input logic [1:0] err);
        checkOutput({who, "_data"}, 64'(d), 64'(e.data));
        checkOutput({who, "_sop"}, 64'(sop), 64'(e.sop));
        checkOutput({who, "_eop"}, 64'(eop), 64'(e.eop));
        checkOutput({who, "_error"}, 64'(err), 64'(e.err));
        checkOutput({who, "_latency"}, 64'(cyc), 64'(e.due));
    endtask

    always @(negedge clk_clk) begin
        if (reset_reset_n && out_valid_s3) begin
            if (q3.size() == 0) checkOutput("s3_unexpected_valid", 64'(1), 64'(0));
            else checkPulse("s3", q3.pop_front(), out_data_s3, out_sop_s3, out_eop_s3, out_error_s3);
        end
        if (reset_reset_n && out_valid_s0) begin
            if (q0.size() == 0) checkOutput("s0_unexpected_valid", 64'(1), 64'(0));
            else checkPulse("s0", q0.pop_front(), out_data_s0, out_sop_s0, out_eop_s0, out_error_s0);
        end
    end

    function automatic exp_t makeExp(input longint sum, input int sh, input logic [1:0] eo,
                                     input logic sop, input logic eop, input int due);
        longint maxV = (longint'(1) <<< 31) - 1;
        longint minV = -(longint'(1) <<< 31);
        longint v    = sum >>> sh;
        logic   sat  = 1'b0;
        exp_t   r;
        if (v > maxV) begin
            v   = maxV;
            sat = 1'b1;
        end else if (v < minV) begin
            v   = minV;
            sat = 1'b1;
        end
        r.data = v[31:0];
        r.sop  = sop;
        r.eop  = eop;
        r.err  = {eo[1] | sat, eo[0]};
        r.due  = due;
        return r;
    endfunction

    task automatic pushExpected(input logic sop, input logic eop, input int due);
        longint     sum = 0;
        logic [1:0] eo = 2'b00;
        int         fillN = (nFrames > 15) ? 15 : nFrames;
        for (int c = 0; c < 8; c++) modelHist[nFrames][c] = frameData[c];
        for (int c = 0; c < 8; c++) begin
            if (modelActive[c] <= fillN) sum += longint'(modelHist[nFrames - modelActive[c]][c]);
            eo |= frameErr[c];
        end
        nFrames++;
        q3.push_back(makeExp(sum, 3, eo, sop, eop, due));
        q0.push_back(makeExp(sum, 0, eo, sop, eop, due));
    endtask

    task automatic modelReset();
        nFrames = 0;
        for (int c = 0; c < 8; c++) begin
            modelShadow[c] = 0;
            modelActive[c] = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_clk); #1;
            in_valid         = 1'b0;
            in_startofpacket = 1'b0;
            in_endofpacket   = 1'b0;
            in_error         = 2'b00;
            slave_write      = 1'b0;
        end
    endtask

    // One clean frame 0..7 at one sample per clock, with an optional delay
    // write on sample index wrAt (-1 for none).
    task automatic applyStimulus(input logic sop, input logic eop,
                                 input int wrAt, input int wrAddr, input int wrVal);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk_clk); #1;
            if (c == 0) begin
                for (int k = 0; k < 8; k++) modelActive[k] = modelShadow[k];
            end
            in_valid         = 1'b1;
            in_channel       = 3'(c);
            in_data          = frameData[c];
            in_startofpacket = sop && (c == 0);
            in_endofpacket   = eop && (c == 7);
            in_error         = frameErr[c];
            slave_write      = (c == wrAt);
            if (c == wrAt) begin
                slave_address   = 3'(wrAddr);
                slave_writedata = 16'hA5A0 | 16'(wrVal);
                modelShadow[wrAddr] = wrVal;
            end
            if (c == 7) pushExpected(sop, eop, cyc + 2);
        end
    endtask

    task automatic sendRaw(input int ch, input logic [31:0] d);
        @(posedge clk_clk); #1;
        if (ch == 0) begin
            for (int k = 0; k < 8; k++) modelActive[k] = modelShadow[k];
        end
        in_valid         = 1'b1;
        in_channel       = 3'(ch);
        in_data          = d;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
        in_error         = 2'b00;
        slave_write      = 1'b0;
    endtask

    task automatic writeDelay(input int addr, input int val);
        @(posedge clk_clk); #1;
        in_valid        = 1'b0;
        slave_write     = 1'b1;
        slave_address   = 3'(addr);
        slave_writedata = 16'h5F30 | 16'(val);
        modelShadow[addr] = val;
        idle(1);
    endtask

    task automatic resetDut();
        @(posedge clk_clk); #1;
        reset_reset_n = 1'b0;
        in_valid      = 1'b0;
        slave_write   = 1'b0;
        #1;
        checkOutput("rst_s3_data", 64'(out_data_s3), 64'(0));
        checkOutput("rst_s3_valid", 64'(out_valid_s3), 64'(0));
        checkOutput("rst_s3_flags", 64'({out_sop_s3, out_eop_s3, out_error_s3}), 64'(0));
        checkOutput("rst_s0_data", 64'(out_data_s0), 64'(0));
        checkOutput("rst_s0_flags", 64'({out_valid_s0, out_sop_s0, out_eop_s0, out_error_s0}), 64'(0));
        repeat (2) @(posedge clk_clk);
        #1;
        reset_reset_n = 1'b1;
        modelReset();
    endtask

    task automatic fillData(input logic signed [31:0] v);
        for (int c = 0; c < 8; c++) begin
            frameData[c] = v;
            frameErr[c]  = 2'b00;
        end
    endtask

    initial begin
        modelReset();
        fillData(0);
        resetDut();

        // Stray samples while hunting for channel 0 are ignored.
        sendRaw(3, 32'd999);
        sendRaw(5, 32'd1);
        idle(1);

        // All delays zero, constant 1000 on every channel.
        fillData(1000);
        repeat (5) applyStimulus(1'b1, 1'b1, -1, 0, 0);
        idle(3);

        // Long delay on channel 0 right after reset: stale history is gated.
        resetDut();
        writeDelay(0, 15);
        for (int f = 0; f < 17; f++) begin
            fillData(0);
            frameData[0] = 32'sh7FFFFFFF;
            applyStimulus(1'b1, 1'b0, -1, 0, 0);
        end
        idle(3);

        // Impulse on channel 3 with a two-frame delay.
        resetDut();
        writeDelay(3, 2);
        for (int f = 0; f < 10; f++) begin
            fillData(0);
            if (f == 5) frameData[3] = 32'sd8000;
            applyStimulus(f[0] == 1'b0, 1'b1, -1, 0, 0);
        end
        idle(3);

        // Full-scale positive and negative frames, then input error bits.
        resetDut();
        fillData(32'sh7FFFFFFF);
        repeat (2) applyStimulus(1'b1, 1'b1, -1, 0, 0);
        fillData(32'sh80000000);
        repeat (2) applyStimulus(1'b1, 1'b1, -1, 0, 0);
        fillData(100);
        frameErr[2] = 2'b01;
        frameErr[5] = 2'b10;
        applyStimulus(1'b0, 1'b1, -1, 0, 0);
        idle(3);

        // Out-of-order channel drops the frame; a clean frame follows.
        sendRaw(0, 32'd50);
        sendRaw(1, 32'd50);
        sendRaw(2, 32'd50);
        sendRaw(5, 32'd50);
        fillData(16);
        applyStimulus(1'b1, 1'b1, -1, 0, 0);
        // A channel 0 arriving early restarts the frame.
        sendRaw(0, 32'd77);
        sendRaw(1, 32'd77);
        sendRaw(2, 32'd77);
        fillData(-64);
        applyStimulus(1'b1, 1'b1, -1, 0, 0);
        idle(3);

        // Forty frames of random data with delay writes at various points.
        resetDut();
        for (int f = 0; f < 40; f++) begin
            int wrAt = -1;
            int wrAddr = 0;
            int wrVal = 0;
            for (int c = 0; c < 8; c++) begin
                frameData[c] = 32'(int'($urandom_range(0, 4000)) - 2000);
                frameErr[c]  = 2'b00;
            end
            case (f)
                2:  begin wrAt = 3; wrAddr = 1; wrVal = 4;  end
                10: begin wrAt = 0; wrAddr = 5; wrVal = 9;  end
                20: begin wrAt = 6; wrAddr = 7; wrVal = 15; end
                27: begin wrAt = 7; wrAddr = 1; wrVal = 0;  end
                33: begin wrAt = 4; wrAddr = 3; wrVal = 1;  end
                default: ;
            endcase
            applyStimulus(f[0] == 1'b0, f[1] == 1'b0, wrAt, wrAddr, wrVal);
        end
        idle(3);

        // Reset in the middle of a frame produces no output for it.
        sendRaw(0, 32'd5);
        sendRaw(1, 32'd5);
        sendRaw(2, 32'd5);
        sendRaw(3, 32'd5);
        resetDut();
        fillData(24);
        applyStimulus(1'b1, 1'b1, -1, 0, 0);
        idle(4);

        checkOutput("s3_pending_at_end", 64'(q3.size()), 64'(0));
        checkOutput("s0_pending_at_end", 64'(q0.size()), 64'(0));
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, %0d/%0d so far", passCount, checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
